// File: rtl/shared_reg_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// shared_reg_pkg
//   Shared types and width helpers for the shared-register arbiter.
//   - arb_state_e : two-state arbiter FSM encoding
//   - idx_width() : width of a requester index (ptr / owner)
//   - hold_width(): width of the burst hold counter
// ----------------------------------------------------------------------------
package shared_reg_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_e;

   localparam int DEFAULT_WIDTH    = 32;
   localparam int DEFAULT_N        = 4;
   localparam int DEFAULT_MAX_HOLD = 4;

   // Requester index width; never below one bit so the ports stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Hold counter must be able to represent MAX_HOLD itself.
   function automatic int hold_width(input int max_hold);
      return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker.
//   Scans ptr+1, ptr+2, ... modulo N; the ptr position itself is scanned last.
//   Ports:
//     req    in  N      request vector
//     ptr    in  IW     priority pointer (last served index)
//     valid  out 1      at least one request present
//     winner out IW     index of the selected requester
//     onehot out N      one-hot form of winner (all-zero when !valid)
// ----------------------------------------------------------------------------
module rr_pick
   import shared_reg_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic [N-1:0]            req,
   input  logic [idx_width(N)-1:0] ptr,
   output logic                    valid,
   output logic [idx_width(N)-1:0] winner,
   output logic [N-1:0]            onehot
);

   localparam int IW = idx_width(N);

   int idx;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise the tool infers a latch.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      onehot = '0;
      idx    = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!valid && req[idx]) begin
            valid       = 1'b1;
            winner      = IW'(idx);
            onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register among N requesters.
//   The owner's value is committed each cycle it keeps req high; the previous
//   contents are exposed on prev. An owner holding lock may keep the grant for
//   up to MAX_HOLD consecutive commits, after which it is forced to release.
//   Ports:
//     clk      in  1        clock, state updates on posedge
//     reset    in  1        asynchronous active-low reset
//     req      in  N        per-requester request
//     lock     in  N        per-requester burst request (owner's bit only)
//     data     in  N*WIDTH  requester i value in [i*WIDTH +: WIDTH]
//     grant    out N        registered one-hot grant, zero when idle
//     owner    out IW       current or most recent grantee
//     busy     out 1        high while in GRANTED
//     out      out WIDTH    shared register contents
//     prev     out WIDTH    out value before the most recent commit
//     updated  out 1        pulse in the cycle out first shows a new value
// ----------------------------------------------------------------------------
module shared_reg_arbiter
   import shared_reg_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int N        = DEFAULT_N,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            lock,
   input  logic [N*WIDTH-1:0]      data,
   output logic [N-1:0]            grant,
   output logic [idx_width(N)-1:0] owner,
   output logic                    busy,
   output logic [WIDTH-1:0]        out,
   output logic [WIDTH-1:0]        prev,
   output logic                    updated
);

   localparam int IW = idx_width(N);
   localparam int HW = hold_width(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_e      state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic [N-1:0]    grant_nxt;
   logic [IW-1:0]   owner_nxt;
   logic [WIDTH-1:0] out_nxt, prev_nxt;
   logic            updated_nxt;

   // Unpacked view of the data bus so only the owner's slice is ever selected;
   // X on other requesters' data cannot reach the register.
   logic [WIDTH-1:0] data_arr [N];

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign data_arr[i] = data[i*WIDTH +: WIDTH];
   end

   logic             owner_req;
   logic             owner_lock;
   logic [WIDTH-1:0] owner_data;

   assign owner_req  = req[owner];
   assign owner_lock = lock[owner];
   assign owner_data = data_arr[owner];

   // One picker serves both cases: from IDLE it scans after ptr; on release it
   // scans after the outgoing owner, so the owner's own request comes last.
   logic [IW-1:0] pick_ptr;
   logic          pick_valid;
   logic [IW-1:0] pick_winner;
   logic [N-1:0]  pick_onehot;

   assign pick_ptr = (state == IDLE) ? ptr : owner;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .valid  (pick_valid),
      .winner (pick_winner),
      .onehot (pick_onehot)
   );

   // ------------------------------------------------------------------------
   // State register (all flops)
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= IW'(N - 1);
         hold_cnt <= '0;
         grant    <= '0;
         owner    <= '0;
         out      <= '0;
         prev     <= '0;
         updated  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         grant    <= grant_nxt;
         owner    <= owner_nxt;
         out      <= out_nxt;
         prev     <= prev_nxt;
         updated  <= updated_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      grant_nxt   = grant;
      owner_nxt   = owner;
      out_nxt     = out;
      prev_nxt    = prev;
      updated_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_nxt = pick_onehot;
               owner_nxt = pick_winner;
               hold_nxt  = '0;
               state_nxt = GRANTED;
            end
         end

         GRANTED: begin
            if (owner_req) begin
               out_nxt     = owner_data;
               prev_nxt    = out;
               updated_nxt = 1'b1;
            end

            if (owner_req && owner_lock && (hold_cnt < HOLD_LAST)) begin
               // Burst continues: keep the grant, count the commit.
               hold_nxt = hold_cnt + 1'b1;
            end else begin
               // Release (commit without lock, forced release, or abandon):
               // re-arbitrate in the same cycle so there is no bubble.
               ptr_nxt  = owner;
               hold_nxt = '0;
               if (pick_valid) begin
                  grant_nxt = pick_onehot;
                  owner_nxt = pick_winner;
               end else begin
                  grant_nxt = '0;
                  state_nxt = IDLE;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      busy = (state == GRANTED);
   end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit state register among N requesters.
- Each requester offers a value with a req/grant handshake. The winner's value is committed into the shared register, and the previous contents are kept as a "prev" view.
- Optional lock lets one requester own the register for a bounded burst of consecutive writes.
- Sits between pipeline stages that contend for a single stored value, such as a shared accumulator or shared config word.

Parameters:
WIDTH, 32, bit width of stored value and each requester's data
N, 4, number of requesters (N >= 2)
MAX_HOLD, 4, max consecutive commits per grant while lock is held (>= 1; 1 disables locking)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
req  input  N  per-requester request; must stay high until a grant is seen
lock  input  N  per-requester burst request; sampled only for the current owner
data  input  N*WIDTH  requester i's value in bits [i*WIDTH +: WIDTH]
grant  output  N  registered one-hot grant, all-zero when idle
owner  output  $clog2(N)  index of the current or most recent grantee
busy  output  1  high while state is GRANTED
out  output  WIDTH  shared register contents
prev  output  WIDTH  value out held before the most recent commit
updated  output  1  one-cycle pulse, high in the cycle out first shows a new value

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are named clk and reset.
- Reset (reset == 0, takes effect immediately, no clock needed):
  - state = IDLE, grant = 0, owner = 0, out = 0, prev = 0, updated = 0, hold_cnt = 0.
  - Priority pointer ptr = N-1, so requester 0 has top priority first.
  - An in-flight grant is dropped with no partial write.
- Pick function: winner = first i with req[i] set, scanning ptr+1, ptr+2, … modulo N. The ptr position itself is scanned last.
- State IDLE:
  - If req is nonzero: on the next edge grant <= onehot(winner), owner <= winner, hold_cnt <= 0, state <= GRANTED.
  - Otherwise no change.
- State GRANTED, commit case (req[owner] == 1):
  - On the edge: out <= data[owner], prev <= out, updated <= 1.
  - Continue: if lock[owner] and hold_cnt < MAX_HOLD-1, then hold_cnt++ and the grant is kept.
  - Release: otherwise ptr <= owner and re-arbitrate in the same cycle. The new winner is granted on that edge with no bubble, and hold_cnt <= 0. If req has no other bit set and the owner drops req, state <= IDLE and grant <= 0.
  - When re-arbitrating, the owner's own req is scanned last. A requester that keeps req high regains the grant only if nobody else requests.
- State GRANTED, abandon case (req[owner] == 0):
  - No write; updated <= 0.
  - Release exactly as above; ptr <= owner.
- updated is 0 in every cycle where no commit happened on the preceding edge.
- Throughput:
  - One commit per cycle under continuous contention.
  - One idle cycle (grant latency) after IDLE.
  - Latency from req to out updated is 2 edges from IDLE.
- A forced release at MAX_HOLD happens even if lock is still high. The locked requester re-enters arbitration at lowest priority.
- lock and data of non-owners are ignored. X on them must not propagate.
- hold_cnt width is $clog2(MAX_HOLD+1). ptr and owner width is $clog2(N).
- Commits and arbitration in the same cycle are legal; prev always tracks the last pre-commit out.

Decomposition:
- Package shared_reg_pkg holds:
  - typedef enum logic {IDLE, GRANTED} arb_state_e;
  - localparam helpers for the index width (clog2 of N) and the hold-counter width.
- Sub-module rr_pick: purely combinational, parameter N. Inputs req and ptr; outputs valid, winner index and one-hot grant. It is reused for both the IDLE grant and the release re-arbitration.
- All flops live in the top module with the async active-low reset.

Test Plan (all scenarios use N=4, WIDTH=8, MAX_HOLD=3):
1. Single request:
   - Stimulus: release reset; hold req=0100, data[2]=A5.
   - Edge 1: grant=0100, busy=1.
   - Edge 2: out=A5, prev=00, updated=1.
   - With req dropped after edge 2: edge 3 gives grant=0, busy=0, updated=0.
2. Full contention:
   - Stimulus: req=1111 held, data[i]=10+i, no lock.
   - Required: grants 0001, 0010, 0100, 1000, 0001 on consecutive edges.
   - out sequence 10, 11, 12, 13; updated held high from the 2nd edge onward.
3. Lock burst:
   - Stimulus: req=1010, lock[1]=1 held, and requester 1 is granted first. Its data changes each cycle: 11, 22, 33, 44.
   - Required: exactly 3 commits (11, 22, 33), then forced release with grant=1000 on the next edge; 44 is not written.
   - Then grant returns to 0010 after requester 3 commits.
4. Abandon:
   - Stimulus: req=0100 for one cycle only.
   - Required: grant=0100 for one cycle, no write (out unchanged, updated=0), then IDLE with grant=0.
   - ptr has moved to 2: a following req=0101 grants 0001 first.
5. Async reset mid-burst:
   - Stimulus: during scenario 2, drive reset low between edges.
   - Required: grant, out, prev, updated go to 0 before the next edge; no commit on that edge.
   - After release with req=1111, requester 0 is granted first.
6. Wrap-around:
   - Stimulus: after requester 3 commits (ptr=3), drive req=1001.
   - Required: grant=0001 wins over requester 3.
